// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I MEM-stage load/store unit between EX/MEM and MEM/WB, driving a valid/ready data bus.
// Latency: load 3 cycles minimum (issue, response, done), store 2 cycles; non-memory ops pass through combinationally.
// Backpressure: mem_stall holds PC..EX/MEM while an access is outstanding; dmem_req_* is held stable until dmem_req_ready.
// Ports: clk/reset (sync, active-low); ex_* EX/MEM fields in; dmem_* request/response bus;
//        mem_stall, misalign_err; *_out fields to the MEM/WB register.
// Option: define LSU_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog and a bus_err output pulse.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        misalign_err,
    output logic [31:0] mem_read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        mem_to_reg_out
`ifdef LSU_TIMEOUT_EN
    ,
    output logic        bus_err
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;

    logic        is_load, is_store, mem_op;
    logic        misalign, illegal, bad_access;
    logic [1:0]  a_lo;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;
    logic        req_vld, stall, err, in_done;
    logic        tmo;       // watchdog expiry this cycle
    logic        tmo_done;  // current DONE was reached by watchdog expiry

    assign a_lo     = ex_alu_result[1:0];
    assign is_load  = ex_mem_read;
    assign is_store = ex_mem_write & ~ex_mem_read;
    assign mem_op   = ex_valid & (ex_mem_read | ex_mem_write);

    always_comb begin
        illegal  = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111);
        misalign = 1'b0;
        case (ex_funct3[1:0])
            2'b01:   misalign = a_lo[0];
            2'b10:   misalign = (a_lo != 2'b00);
            default: misalign = 1'b0;
        endcase
        bad_access = illegal | misalign;
    end

    // Store lanes: data is replicated so the strobes alone select the target bytes.
    always_comb begin
        wstrb = 4'hF;
        wdata = ex_store_data;
        case (ex_funct3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << a_lo;
                wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                wstrb = 4'b0011 << {a_lo[1], 1'b0};
                wdata = {2{ex_store_data[15:0]}};
            end
            default: begin
                wstrb = 4'hF;
                wdata = ex_store_data;
            end
        endcase
    end

    always_comb begin
        byte_sel = dmem_rdata[7:0];
        case (a_lo)
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            2'd3:    byte_sel = dmem_rdata[31:24];
            default: byte_sel = dmem_rdata[7:0];
        endcase
        half_sel = a_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_fmt = dmem_rdata;
        case (ex_funct3)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_fmt = {24'h0, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_fmt = {16'h0, half_sel};
            default: load_fmt = dmem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tout_q;

    assign tmo      = ((state_q == REQ) || (state_q == WAIT_RSP)) &&
                      (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign tmo_done = tout_q;
    assign bus_err  = tmo;

    // Counts cycles spent in the current waiting state; any state change restarts it.
    always_comb begin
        cnt_d = '0;
        if (((state_q == REQ) || (state_q == WAIT_RSP)) && (state_d == state_q))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= tmo;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo      = 1'b0;
    assign tmo_done = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        req_vld = 1'b0;
        stall   = 1'b0;
        err     = 1'b0;
        in_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (bad_access) begin
                        err = 1'b1;
                    end else begin
                        req_vld = 1'b1;
                        stall   = 1'b1;
                        if (dmem_req_ready) state_d = is_load ? WAIT_RSP : DONE;
                        else                state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (tmo) begin
                    state_d = DONE;
                end else begin
                    req_vld = 1'b1;
                    if (dmem_req_ready) state_d = is_load ? WAIT_RSP : DONE;
                end
            end
            WAIT_RSP: begin
                stall = 1'b1;
                if (tmo) begin
                    state_d = DONE;
                end else if (dmem_rsp_valid) begin
                    rdata_d = load_fmt;
                    state_d = DONE;
                end
            end
            DONE: begin
                in_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // Request fields come straight from EX/MEM, which mem_stall freezes while the request is pending.
    assign dmem_req_valid = req_vld;
    assign dmem_we        = is_store;
    assign dmem_addr      = {ex_alu_result[31:2], 2'b00};
    assign dmem_wdata     = wdata;
    assign dmem_wstrb     = is_store ? wstrb : 4'h0;
    assign mem_stall      = stall;
    assign misalign_err   = err;

    // A stalled cycle presents a bubble to MEM/WB.
    assign alu_result_out    = ex_alu_result;
    assign mem_to_reg_out    = ex_mem_to_reg;
    assign rd_out            = stall ? 5'd0 : ex_rd;
    assign reg_write_out     = ex_valid & ex_reg_write & ~stall & ~err & ~tmo_done;
    assign mem_read_data_out = (in_done && is_load && !tmo_done) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
`timescale 1ns/1ps
module tb_mem_stage_lsu;
`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic [31:0] ex_alu_result, ex_store_data, dmem_rdata;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        dmem_req_ready, dmem_rsp_valid;
    logic        dmem_req_valid, dmem_we, mem_stall, misalign_err, reg_write_out, mem_to_reg_out;
    logic [31:0] dmem_addr, dmem_wdata, mem_read_data_out, alu_result_out;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  rd_out;
`ifdef LSU_TIMEOUT_EN
    logic        bus_err;
`endif

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .misalign_err(misalign_err),
        .mem_read_data_out(mem_read_data_out), .alu_result_out(alu_result_out),
        .rd_out(rd_out), .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out)
`ifdef LSU_TIMEOUT_EN
        , .bus_err(bus_err)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] addr;
        logic [3:0]  strb;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference load formatting: shift the addressed lane down, then extend.
    function automatic logic [31:0] model_load(logic [31:0] w, logic [2:0] f3, logic [1:0] a);
        logic [31:0] s;
        s = w >> (a * 8);
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic drive_idle();
        ex_valid = 0; ex_alu_result = 0; ex_store_data = 0; ex_rd = 0; ex_funct3 = 0;
        ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; ex_mem_to_reg = 0;
    endtask

    task automatic drive_op(input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                            input logic [2:0] f3, input logic mr, input logic mw, input logic rw);
        ex_valid = 1; ex_alu_result = addr; ex_store_data = sd; ex_rd = rd; ex_funct3 = f3;
        ex_mem_read = mr; ex_mem_write = mw; ex_reg_write = rw; ex_mem_to_reg = mr;
    endtask

    // Runs one load with immediate ready and a response one cycle later; returns what MEM/WB saw.
    task automatic do_load(input logic [31:0] addr, input logic [31:0] word, input logic [2:0] f3,
                           input logic [4:0] rd, output logic [31:0] od, output logic [4:0] ord,
                           output logic orw, output logic [31:0] oaddr, output logic ovld,
                           output int stalls, output bit tmo);
        drive_op(addr, 32'h0, rd, f3, 1'b1, 1'b0, 1'b1);
        dmem_req_ready = 1;
        stalls = 0; tmo = 1; od = 0; ord = 0; orw = 0;
        @(negedge clk);
        oaddr = dmem_addr; ovld = dmem_req_valid;
        if (mem_stall) stalls++;
        @(posedge clk); #1;
        dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rdata = word;
        @(negedge clk);
        if (mem_stall) stalls++;
        @(posedge clk); #1;
        dmem_rsp_valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!mem_stall) begin
                od = mem_read_data_out; ord = rd_out; orw = reg_write_out; tmo = 0;
                break;
            end
            stalls++;
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_reset();
        reset = 0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (dmem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", dmem_req_valid); else n_pass++;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", mem_stall); else n_pass++;
        n_checks++; if (reg_write_out !== 1'b0) $display("FAIL reset_reg_write: got %b want 0", reg_write_out); else n_pass++;
        n_checks++; if (mem_read_data_out !== 32'h0) $display("FAIL reset_rdata: got %h want 0", mem_read_data_out); else n_pass++;
        @(posedge clk); #1;
        reset = 1;
    endtask

    task automatic test_passthrough();
        logic [31:0] alu [3] = '{32'h55, 32'hFFFF_0000, 32'h1};
        logic [4:0]  rdv [3] = '{5'd7, 5'd31, 5'd3};
        logic        rwv [3] = '{1'b1, 1'b1, 1'b0};
        logic        vv  [3] = '{1'b1, 1'b0, 1'b1};
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            drive_op(alu[k], 32'h0, rdv[k], 3'b000, 1'b0, 1'b0, rwv[k]);
            ex_valid = vv[k];
            sb_q.push_back('{data: alu[k], rd: rdv[k], rw: rwv[k] & vv[k], addr: 32'h0, strb: 4'h0});
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++; if (alu_result_out !== e.data) $display("FAIL pass_alu[%0d]: got %h want %h", k, alu_result_out, e.data); else n_pass++;
            n_checks++; if (rd_out !== e.rd) $display("FAIL pass_rd[%0d]: got %0d want %0d", k, rd_out, e.rd); else n_pass++;
            n_checks++; if (reg_write_out !== e.rw) $display("FAIL pass_rw[%0d]: got %b want %b", k, reg_write_out, e.rw); else n_pass++;
            n_checks++; if ({mem_stall, dmem_req_valid} !== 2'b00) $display("FAIL pass_stall_req[%0d]: got %b want 00", k, {mem_stall, dmem_req_valid}); else n_pass++;
            n_checks++; if (mem_read_data_out !== 32'h0) $display("FAIL pass_rdata[%0d]: got %h want 0", k, mem_read_data_out); else n_pass++;
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    task automatic test_lw();
        logic [31:0] od, oaddr; logic [4:0] ord; logic orw, ovld; int st; bit tmo; exp_t e;
        sb_q.push_back('{data: 32'hDEADBEEF, rd: 5'd5, rw: 1'b1, addr: 32'h100, strb: 4'h0});
        do_load(32'h100, 32'hDEADBEEF, 3'b010, 5'd5, od, ord, orw, oaddr, ovld, st, tmo);
        e = sb_q.pop_front();
        n_checks++; if (tmo) $display("FAIL lw_done: got no completion want completion within 10 cycles"); else n_pass++;
        n_checks++; if (ovld !== 1'b1 || oaddr !== e.addr) $display("FAIL lw_req: got vld=%b addr=%h want vld=1 addr=%h", ovld, oaddr, e.addr); else n_pass++;
        n_checks++; if (st != 2) $display("FAIL lw_stall_cycles: got %0d want 2", st); else n_pass++;
        n_checks++; if (od !== e.data) $display("FAIL lw_data: got %h want %h", od, e.data); else n_pass++;
        n_checks++; if (ord !== e.rd || orw !== e.rw) $display("FAIL lw_rd_rw: got rd=%0d rw=%b want rd=%0d rw=%b", ord, orw, e.rd, e.rw); else n_pass++;
    endtask

    task automatic test_sub_word_loads();
        logic [2:0]  f3v [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] av  [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] od, oaddr; logic [4:0] ord; logic orw, ovld; int st; bit tmo; exp_t e;
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back('{data: model_load(32'h80FF_0000, f3v[k], av[k][1:0]), rd: 5'(k + 10),
                             rw: 1'b1, addr: 32'h100, strb: 4'h0});
            do_load(av[k], 32'h80FF_0000, f3v[k], 5'(k + 10), od, ord, orw, oaddr, ovld, st, tmo);
            e = sb_q.pop_front();
            n_checks++; if (tmo || od !== e.data) $display("FAIL subload_data[%0d]: got %h (timeout=%0d) want %h", k, od, tmo, e.data); else n_pass++;
            n_checks++; if (oaddr !== e.addr) $display("FAIL subload_addr[%0d]: got %h want %h", k, oaddr, e.addr); else n_pass++;
        end
    endtask

    task automatic test_stores();
        logic [31:0] av [3] = '{32'h202, 32'h201, 32'h300};
        logic [31:0] dv [3] = '{32'h1234ABCD, 32'h000000A5, 32'hCAFEF00D};
        logic [2:0]  fv [3] = '{3'b001, 3'b000, 3'b010};
        int          dl [3] = '{3, 0, 1};
        logic [3:0]  strb; logic [31:0] wd; exp_t e; int vld_cycles;
        for (int k = 0; k < 3; k++) begin
            case (fv[k])
                3'b000:  begin strb = 4'b0001 << av[k][1:0]; wd = {4{dv[k][7:0]}}; end
                3'b001:  begin strb = av[k][1] ? 4'b1100 : 4'b0011; wd = {2{dv[k][15:0]}}; end
                default: begin strb = 4'hF; wd = dv[k]; end
            endcase
            sb_q.push_back('{data: wd, rd: 5'd0, rw: 1'b0, addr: {av[k][31:2], 2'b00}, strb: strb});
            drive_op(av[k], dv[k], 5'd0, fv[k], 1'b0, 1'b1, 1'b0);
            dmem_req_ready = (dl[k] == 0);
            e = sb_q.pop_front();
            vld_cycles = 0;
            for (int c = 0; c <= dl[k]; c++) begin
                @(negedge clk);
                if (dmem_req_valid) vld_cycles++;
                n_checks++;
                if ({dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== {1'b1, e.addr, e.data, e.strb})
                    $display("FAIL store_fields[%0d] cycle %0d: got we=%b addr=%h wdata=%h wstrb=%b want we=1 addr=%h wdata=%h wstrb=%b",
                             k, c, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, e.addr, e.data, e.strb);
                else n_pass++;
                @(posedge clk); #1;
                dmem_req_ready = (c + 1 == dl[k]);
            end
            @(negedge clk);
            n_checks++; if (vld_cycles != dl[k] + 1) $display("FAIL store_vld_cycles[%0d]: got %0d want %0d", k, vld_cycles, dl[k] + 1); else n_pass++;
            n_checks++; if ({mem_stall, dmem_req_valid, reg_write_out} !== 3'b000) $display("FAIL store_done[%0d]: got stall/vld/rw=%b want 000", k, {mem_stall, dmem_req_valid, reg_write_out}); else n_pass++;
            @(posedge clk); #1;
            drive_idle();
        end
    endtask

    task automatic test_misalign();
        logic [31:0] av [4] = '{32'h101, 32'h203, 32'h100, 32'h102};
        logic [2:0]  fv [4] = '{3'b010, 3'b001, 3'b011, 3'b010};
        logic        rv [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            drive_op(av[k], 32'h5A5A5A5A, 5'd4, fv[k], rv[k], ~rv[k], rv[k]);
            @(negedge clk);
            n_checks++; if (misalign_err !== 1'b1) $display("FAIL misalign_err[%0d]: got %b want 1", k, misalign_err); else n_pass++;
            n_checks++; if ({dmem_req_valid, mem_stall, reg_write_out} !== 3'b000) $display("FAIL misalign_quiet[%0d]: got vld/stall/rw=%b want 000", k, {dmem_req_valid, mem_stall, reg_write_out}); else n_pass++;
            @(posedge clk); #1;
            drive_idle();
            @(negedge clk);
            n_checks++; if ({misalign_err, mem_stall} !== 2'b00) $display("FAIL misalign_pulse[%0d]: got err/stall=%b want 00", k, {misalign_err, mem_stall}); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        drive_op(32'h100, 32'h0, 5'd9, 3'b010, 1'b1, 1'b0, 1'b1);
        dmem_req_ready = 1;
        @(posedge clk); #1;
        dmem_req_ready = 0;
        @(negedge clk);
        n_checks++; if ({mem_stall, dmem_req_valid} !== 2'b10) $display("FAIL rstmid_wait: got stall/vld=%b want 10", {mem_stall, dmem_req_valid}); else n_pass++;
        reset = 0;
        drive_idle();
        @(posedge clk); #1;
        reset = 1; dmem_rsp_valid = 1; dmem_rdata = 32'h12345678;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_stall, dmem_req_valid, reg_write_out, misalign_err} !== 4'b0000 ||
                rd_out !== 5'd0 || mem_read_data_out !== 32'h0 || alu_result_out !== 32'h0)
                $display("FAIL rstmid_idle[%0d]: got stall=%b vld=%b rw=%b err=%b rd=%0d rdata=%h alu=%h want all 0",
                         c, mem_stall, dmem_req_valid, reg_write_out, misalign_err, rd_out, mem_read_data_out, alu_result_out);
            else n_pass++;
            @(posedge clk); #1;
            dmem_rsp_valid = 0;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] od, oaddr; logic [4:0] ord; logic orw, ovld; int st; bit tmo; exp_t e;
        logic [31:0] wv [2] = '{32'h0BAD_F00D, 32'h7F00_00C3};
        logic [2:0]  fv [2] = '{3'b010, 3'b100};
        for (int k = 0; k < 2; k++)
            sb_q.push_back('{data: model_load(wv[k], fv[k], 2'(k * 3)), rd: 5'(20 + k), rw: 1'b1, addr: 32'h400, strb: 4'h0});
        for (int k = 0; k < 2; k++) begin
            do_load(32'h400 + 32'(k * 3), wv[k], fv[k], 5'(20 + k), od, ord, orw, oaddr, ovld, st, tmo);
            e = sb_q.pop_front();
            n_checks++; if (tmo || od !== e.data || ord !== e.rd || st != 2)
                $display("FAIL b2b[%0d]: got data=%h rd=%0d stalls=%0d timeout=%0d want data=%h rd=%0d stalls=2", k, od, ord, st, tmo, e.data, e.rd);
            else n_pass++;
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int cyc = 0;
        bit seen = 0;
        drive_op(32'h100, 32'h0, 5'd6, 3'b010, 1'b1, 1'b0, 1'b1);
        dmem_req_ready = 1;
        @(posedge clk); #1;
        dmem_req_ready = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_err) begin cyc = i + 1; seen = 1; break; end
        end
        n_checks++; if (!seen || cyc != TO) $display("FAIL timeout_cycles: got %0d (seen=%0d) want %0d", cyc, seen, TO); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if ({mem_stall, reg_write_out, bus_err} !== 3'b000) $display("FAIL timeout_done: got stall/rw/err=%b want 000", {mem_stall, reg_write_out, bus_err}); else n_pass++;
        @(posedge clk); #1;
        drive_idle();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
        drive_idle();
        test_reset();
        test_passthrough();
        test_lw();
        test_sub_word_loads();
        test_stores();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit for the RV32I 5-stage pipeline.
- Consumes EX/MEM fields and drives a valid/ready data-memory bus.
- Produces the MEM/WB register inputs (read data, ALU result, rd, reg_write, mem_to_reg).
- Stalls the front of the pipeline while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only when LSU_TIMEOUT_EN is defined).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- ex_valid  in  1  EX/MEM holds a real instruction
- ex_alu_result  in  32  address for memory ops; result for the others
- ex_store_data  in  32  rs2 value for stores
- ex_rd  in  5  destination register
- ex_funct3  in  3  access size/sign (RV32I encoding)
- ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  in  1 each  control
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  request accepted
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte strobes (0 for loads)
- dmem_rsp_valid  in  1  load data valid
- dmem_rdata  in  32  load word
- mem_stall  out  1  hold PC/IF/ID/EX/MEM
- misalign_err  out  1  one-cycle pulse, misaligned or illegal access
- mem_read_data_out  out  32  formatted load data to MEM/WB
- alu_result_out  out  32  to MEM/WB
- rd_out  out  5  to MEM/WB
- reg_write_out, mem_to_reg_out  out  1 each  to MEM/WB

Behaviour:
- Reset (reset==0 at posedge):
  - FSM goes to IDLE; load-data register rdata_q cleared to 0.
  - All registered outputs go to 0; dmem_req_valid=0 from the next cycle.
  - A response arriving after a mid-transaction reset is ignored.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE, non-memory op or ex_valid=0:
  - Pass-through: alu_result_out, rd_out, reg_write_out, mem_to_reg_out take the ex_* values.
  - reg_write_out is gated by ex_valid. mem_stall=0.
- IDLE, aligned memory op:
  - dmem_req_valid=1 combinationally in the same cycle; mem_stall=1.
  - Load: if dmem_req_ready → WAIT_RSP, else → REQ.
  - Store: if dmem_req_ready → DONE, else → REQ.
- REQ: hold dmem_req_valid and every dmem_* field stable until ready; exit is the same as IDLE. mem_stall=1.
- WAIT_RSP:
  - dmem_req_valid=0, mem_stall=1.
  - On dmem_rsp_valid, capture the formatted load into rdata_q → DONE.
  - A response in the same cycle as ready is not possible; any response needs at least one cycle in WAIT_RSP.
- DONE:
  - mem_stall=0; outputs carry the ex_* fields, with mem_read_data_out=rdata_q.
  - → IDLE. EX/MEM advances on this edge.
- While mem_stall=1 the MEM/WB outputs are a bubble: reg_write_out=0, rd_out=0.
- Minimum latency: load = 3 cycles (IDLE+ready, WAIT_RSP+rsp, DONE); store = 2 cycles.
- Misaligned or illegal access:
  - Conditions: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0; funct3 011/110/111 on any mem op.
  - Response: no bus request, misalign_err=1 for one cycle, reg_write_out=0, mem_stall=0.
- Store formatting:
  - SB: wstrb=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: wstrb=4'b0011<<{addr[1],1'b0}, wdata={2{data[15:0]}}.
  - SW: wstrb=4'hF.
- Load formatting:
  - LB/LBU: byte lane addr[1:0], sign- or zero-extended.
  - LH/LHU: half lane addr[1], sign- or zero-extended.
  - LW: whole word.
- mem_read_data_out=0 for non-loads.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A counter runs in REQ/WAIT_RSP and clears on entry.
  - When it reaches TIMEOUT_CYCLES: drop the request, pulse bus_err (extra 1-bit output), go to DONE with reg_write_out=0.
- LSU_TIMEOUT_EN undefined: no counter, no bus_err port; the FSM waits indefinitely.

Test Plan:
- LW at 0x100, ready immediate, rdata=0xDEADBEEF one cycle later → mem_stall high for 2 cycles; in DONE mem_read_data_out=0xDEADBEEF, reg_write_out=1.
- LB at 0x103, rdata=0x80FF_0000 → mem_read_data_out=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202, data 0x1234ABCD, ready held low 3 cycles → dmem_req_valid held 4 cycles, fields stable; wstrb=4'b1100, wdata=0xABCDABCD.
- LW at 0x101 → no dmem_req_valid, misalign_err one pulse, reg_write_out=0, mem_stall=0.
- ADD result 0x55 to rd=7, no mem op → same-cycle pass-through, mem_stall=0, rd_out=7.
- Reset low during WAIT_RSP, then rsp_valid after release → FSM in IDLE, response ignored, all outputs 0. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no rsp → bus_err after 4 cycles, reg_write_out=0.
